// File: rtl/mux_arb_pkg.sv
// Shared definitions for the wormhole output arbiter: flit types, sel width, FSM states.
package mux_arb_pkg;

  localparam int TYPEW   = 2;
  localparam int PORT_P1 = 5;

  typedef enum logic [TYPEW-1:0] {
    TYPE_HEAD = 2'd0,
    TYPE_DATA = 2'd1,
    TYPE_TAIL = 2'd2,
    TYPE_NONE = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_0 = 2'd1,
    ST_LOCK_1 = 2'd2
  } state_e;

endpackage

// File: rtl/mux_arb_rr_pick2.sv
// Two-way round-robin pick: rr names the port that wins a tie.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       rr,
  output logic [1:0] win
);

  // A lone requester always wins; on a tie the rr port wins.
  always_comb begin
    win    = 2'b00;
    win[0] = req0 && (!req1 || !rr);
    win[1] = req1 && (!req0 || rr);
  end

endmodule

// File: rtl/mux_arb.sv
// Two-port wormhole arbiter: a HEAD locks the output to its port until the TAIL passes.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int SELW  = PORT_P1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_0,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             ostall,
  output logic [SELW-1:0]  sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic             busy,
  output logic [15:0]      flit_cnt
);

  logic [NPORT-1:0] req;
  logic [1:0]       win;
  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [15:0]      cnt_q, cnt_d;

  // Only a head flit may open a packet; anything else arriving in IDLE is ignored.
  always_comb begin
    req    = '0;
    req[0] = ivalid_0 && (itype_0 == TYPE_HEAD);
    req[1] = ivalid_1 && (itype_1 == TYPE_HEAD);
  end

  rr_pick2 u_pick (
    .req0 (req[0]),
    .req1 (req[1]),
    .rr   (rr_q),
    .win  (win)
  );

  // Next state, grants and flit counter; grants come straight from the lock state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win[0])      state_d = ST_LOCK_0;
        else if (win[1]) state_d = ST_LOCK_1;
      end
      ST_LOCK_0: begin
        grant_0 = ivalid_0 && !ostall;
        if (grant_0 && (itype_0 == TYPE_TAIL)) begin
          state_d = ST_IDLE;
          rr_d    = 1'b1;
        end
      end
      ST_LOCK_1: begin
        grant_1 = ivalid_1 && !ostall;
        if (grant_1 && (itype_1 == TYPE_TAIL)) begin
          state_d = ST_IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_0 || grant_1) cnt_d = cnt_q + 16'd1;
  end

  // sel is registered alongside the state so it decodes the same lock owner.
  always_comb begin
    sel_d = '0;
    case (state_d)
      ST_LOCK_0: sel_d = SELW'(1);
      ST_LOCK_1: sel_d = SELW'(2);
      default:   sel_d = '0;
    endcase
  end

  // State register; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q != ST_IDLE);
  assign flit_cnt = cnt_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench: upstream flit queues feed the arbiter, a monitor scores each grant.
module tb_mux_arb;
  import mux_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst_ = 1'b1;
  logic             ivalid_0 = 1'b0, ivalid_1 = 1'b0, ostall = 1'b0;
  logic [TYPEW-1:0] itype_0 = TYPE_NONE, itype_1 = TYPE_NONE;
  logic [4:0]       sel;
  logic             grant_0, grant_1, busy;
  logic [15:0]      flit_cnt;

  int tests = 0;
  int fails = 0;

  logic [TYPEW-1:0] q0[$];
  logic [TYPEW-1:0] q1[$];
  int               exp_q[$];
  logic [15:0]      mcnt;

  logic       s_g0, s_g1, s_busy;
  logic [4:0] s_sel;
  logic [15:0] s_cnt;

  int sel_exp[16] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0, 2, 2, 2};

  always #5 clk = ~clk;

  mux_arb #(.NPORT(2), .SELW(5)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .ivalid_0 (ivalid_0),
    .ivalid_1 (ivalid_1),
    .itype_0  (itype_0),
    .itype_1  (itype_1),
    .ostall   (ostall),
    .sel      (sel),
    .grant_0  (grant_0),
    .grant_1  (grant_1),
    .busy     (busy),
    .flit_cnt (flit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 25) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of upstream behaviour: present queue heads, sample at negedge, pop on grant.
  task automatic step();
    ivalid_0 = (q0.size() != 0);
    itype_0  = ivalid_0 ? q0[0] : TYPE_NONE;
    ivalid_1 = (q1.size() != 0);
    itype_1  = ivalid_1 ? q1[0] : TYPE_NONE;
    @(negedge clk);
    s_g0 = grant_0; s_g1 = grant_1; s_busy = busy; s_sel = sel; s_cnt = flit_cnt;
    @(posedge clk);
    #1;
    if (s_g0 && q0.size() != 0) void'(q0.pop_front());
    if (s_g1 && q1.size() != 0) void'(q1.pop_front());
  endtask

  task automatic push_pkt(input int port, input int ndata);
    if (port == 0) q0.push_back(TYPE_HEAD); else q1.push_back(TYPE_HEAD);
    for (int i = 0; i < ndata; i++)
      if (port == 0) q0.push_back(TYPE_DATA); else q1.push_back(TYPE_DATA);
    if (port == 0) q0.push_back(TYPE_TAIL); else q1.push_back(TYPE_TAIL);
    for (int i = 0; i < ndata + 2; i++) exp_q.push_back(port);
  endtask

  task automatic run_until(input int maxc, input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    chk(name, q0.size() + q1.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    ivalid_0 = 1'b0; ivalid_1 = 1'b0; ostall = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  // Scoreboard monitor: every grant must match the next expected port, sel and count.
  initial begin
    int p;
    mcnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        mcnt = '0;
        chk("rst_no_grant", {30'd0, grant_1, grant_0}, 0);
      end else if (grant_0 || grant_1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {30'd0, grant_1, grant_0}, 0);
        end else begin
          p = exp_q.pop_front();
          chk("grant_port", {30'd0, grant_1, grant_0}, (p == 1) ? 2 : 1);
          chk("grant_sel", {27'd0, sel}, (p == 1) ? 2 : 1);
          chk("grant_cnt", {16'd0, flit_cnt}, {16'd0, mcnt});
          mcnt = mcnt + 16'd1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with a head waiting on port 0
    #1 rst_ = 1'b0;
    ivalid_0 = 1'b1; itype_0 = TYPE_HEAD;
    #2;
    chk("rst_sel", {27'd0, sel}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_grants", {30'd0, grant_1, grant_0}, 0);
    chk("rst_cnt", {16'd0, flit_cnt}, 0);
    ivalid_0 = 1'b0;
    @(posedge clk);
    #1 rst_ = 1'b1;

    // single packet on port 1: head + 20 data + tail
    push_pkt(1, 20);
    step();
    chk("p1_arb_sel", {27'd0, s_sel}, 0);
    chk("p1_arb_busy", {31'd0, s_busy}, 0);
    for (int i = 0; i < 22; i++) begin
      step();
      chk("p1_sel", {27'd0, s_sel}, 2);
      chk("p1_grant", {31'd0, s_g1}, 1);
    end
    step();
    chk("p1_end_sel", {27'd0, s_sel}, 0);
    chk("p1_end_busy", {31'd0, s_busy}, 0);
    chk("p1_end_cnt", {16'd0, s_cnt}, 22);
    // rr must be back at 0: port 0 wins the tie
    push_pkt(0, 0);
    push_pkt(1, 0);
    run_until(20, "rr0_drain");

    // three contended packets after reset: 0, 1, 0, then port 1 alone
    do_reset();
    push_pkt(0, 1); push_pkt(1, 1); push_pkt(0, 1); push_pkt(1, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("cont_sel", {27'd0, s_sel}, sel_exp[i]);
    end
    chk("cont_drain", q0.size() + q1.size() + exp_q.size(), 0);

    // stall mid-packet; a NONE flit is forwarded without releasing the lock
    do_reset();
    q0.push_back(TYPE_HEAD); q0.push_back(TYPE_DATA); q0.push_back(TYPE_NONE);
    q0.push_back(TYPE_DATA); q0.push_back(TYPE_TAIL);
    for (int i = 0; i < 5; i++) exp_q.push_back(0);
    step(); step(); step();
    ostall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_grant", {31'd0, s_g0}, 0);
      chk("stall_sel", {27'd0, s_sel}, 1);
      chk("stall_cnt", {16'd0, s_cnt}, 2);
    end
    ostall = 1'b0;
    run_until(10, "stall_drain");
    step();
    chk("stall_end_cnt", {16'd0, s_cnt}, 5);
    chk("stall_end_busy", {31'd0, s_busy}, 0);

    // stray data on port 1 while idle
    q1.push_back(TYPE_DATA);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_grant", {31'd0, s_g1}, 0);
      chk("stray_busy", {31'd0, s_busy}, 0);
      chk("stray_cnt", {16'd0, s_cnt}, 5);
    end
    q1.delete();

    // reset in LOCK_1 after 5 flits, then relock one cycle after release
    do_reset();
    q1.push_back(TYPE_HEAD);
    for (int i = 0; i < 5; i++) q1.push_back(TYPE_DATA);
    q1.push_back(TYPE_TAIL);
    for (int i = 0; i < 5; i++) exp_q.push_back(1);
    for (int i = 0; i < 6; i++) step();
    #2 rst_ = 1'b0;
    #1;
    chk("midrst_sel", {27'd0, sel}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_grants", {30'd0, grant_1, grant_0}, 0);
    chk("midrst_cnt", {16'd0, flit_cnt}, 0);
    chk("midrst_consumed", exp_q.size(), 0);
    q1.delete(); ivalid_1 = 1'b0;
    @(negedge clk);
    #2 rst_ = 1'b1;
    push_pkt(1, 0);
    step();
    chk("relock_sel", {27'd0, s_sel}, 2);
    chk("relock_busy", {31'd0, s_busy}, 1);
    chk("relock_grant", {31'd0, s_g1}, 1);
    run_until(10, "relock_drain");

    // counter wrap: 65536 granted flits bring the count back to 0
    do_reset();
    push_pkt(0, 65534);
    run_until(70000, "wrap_drain");
    step();
    chk("wrap_zero", {16'd0, s_cnt}, 0);
    push_pkt(1, 0);
    step(); step(); step();
    chk("wrap_next", {16'd0, s_cnt}, 1);
    run_until(10, "wrap_tail_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 The block SHALL take parameters: NPORT, default 2, number of arbitrated inputs; SELW, default `PORT_P1 (5), width of the sel bus.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_  input  1  asynchronous, active-low reset.
REQ-004 ivalid_0 / ivalid_1  input  1  a flit is present at input port 0 / 1.
REQ-005 itype_0 / itype_1  input  `TYPEW  flit type field (TYPE_HEAD, TYPE_DATA, TYPE_TAIL, TYPE_NONE) of the flit at port 0 / 1.
REQ-006 ostall  input  1  downstream cannot accept a flit this cycle.
REQ-007 sel  output  SELW  one-hot select driven to the 2:1 mux; 5'b00001 selects port 0, 5'b00010 selects port 1, 5'b00000 selects no port.
REQ-008 grant_0 / grant_1  output  1  the flit at port 0 / 1 is forwarded this cycle; upstream buffer pops on it.
REQ-009 busy  output  1  a packet currently holds the output.
REQ-010 flit_cnt  output  16  count of granted flits since reset, wrapping.

Function
REQ-011 The FSM SHALL have states IDLE, LOCK_0 and LOCK_1.
REQ-012 In IDLE, port p SHALL request when ivalid_p=1 and itype_p=TYPE_HEAD; non-head flits in IDLE SHALL be ignored and never granted.
REQ-013 With one requester in IDLE, the FSM SHALL move to LOCK_p on the next edge.
REQ-014 With both ports requesting in IDLE, the port named by the round-robin pointer rr SHALL win; rr resets to 0.
REQ-015 Arbitration latency SHALL be one cycle: head presented at cycle t, sel and busy valid from t+1; the upstream holds the head flit until granted.
REQ-016 sel SHALL be a registered function of state only: IDLE gives 0, LOCK_0 gives 5'b00001, LOCK_1 gives 5'b00010.
REQ-017 grant_p SHALL equal (state==LOCK_p) && ivalid_p && !ostall, combinationally; the other grant SHALL be 0.
REQ-018 While locked, ivalid_p=0 or ostall=1 SHALL hold state, rr and flit_cnt unchanged, with no grant.
REQ-019 A granted flit with itype_p=TYPE_TAIL SHALL return the FSM to IDLE on the next edge and set rr to the other port (1-p).
REQ-020 A granted TYPE_HEAD or TYPE_DATA flit SHALL keep the lock; the other port SHALL not be granted until the tail passes (wormhole).
REQ-021 A head and a tail on the same port are never coincident; a TYPE_NONE flit granted while locked SHALL be forwarded and counted but SHALL not release the lock.
REQ-022 flit_cnt SHALL increment by 1 on every cycle with any grant, and SHALL wrap from 16'hFFFF to 0.
REQ-023 busy SHALL be 1 exactly when the state is LOCK_0 or LOCK_1.

Reset
REQ-024 Asserting rst_ low SHALL immediately force state=IDLE, rr=0, sel=0, busy=0, flit_cnt=0, grant_0=grant_1=0, including mid-packet.
REQ-025 The first arbitration after deassertion SHALL occur on the first rising edge with rst_ high.

Structure
REQ-026 TYPEW, TYPE_HEAD/DATA/TAIL/NONE, PORT_P1 and the state encodings SHALL live in the shared define package, not in this module.
REQ-027 The round-robin pick SHALL be one sub-module, rr_pick2 (inputs: two requests and rr; output: one-hot winner); the FSM, registers and counter SHALL be in mux_arb.

Verification
REQ-028 Single packet: port 1 HEAD then 20 DATA then TAIL, port 0 idle -> sel=5'b00010 from cycle 1 to the tail, 22 grant_1 pulses, flit_cnt=22, IDLE after the tail, rr=0.
REQ-029 Contention after reset: HEADs on both ports in the same cycle -> port 0 is locked first; after its TAIL, port 1 is locked on the next cycle; rr alternates 0,1,0 over 3 contended packets.
REQ-030 Stall: ostall=1 for 3 cycles mid-packet -> grant_0=0 for those cycles, sel and flit_cnt hold, and the lock resumes afterwards.
REQ-031 Stray DATA on port 1 in IDLE -> no grant, state stays IDLE, flit_cnt unchanged.
REQ-032 Reset asserted during LOCK_1 after 5 flits -> all outputs are 0 immediately; a new HEAD on port 1 is locked one cycle after release.
REQ-033 Wrap: preload by driving 65536 granted flits -> flit_cnt reads 0 and the next grant reads 1.
